// File: rtl/fpu_sched_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_sched_pkg : shared types and defaults for the FPU scheduler     |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package fpu_sched_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } schedstate_t;

   // Requester id: 0 = FP decode path, 1 = secondary issuer.
   typedef logic reqid_t;

   localparam int unsigned TIMEOUT_DEFAULT = 255;
   localparam int unsigned TOUT_W_DEFAULT  = 8;

   function automatic logic [1:0] id_onehot(input reqid_t id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage
`default_nettype wire

// File: rtl/fpu_rr_arb.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_rr_arb : two-way round-robin grant with a `last` pointer        |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fpu_rr_arb
   import fpu_sched_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       accept,
   output logic [1:0] grant
);

   reqid_t last_q;
   reqid_t last_d;

   // On a tie the requester that did not win last time gets the grant.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = last_q ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_comb begin
      last_d = last_q;
      if (accept) begin
         last_d = grant[1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_q <= 1'b1;
      end else begin
         last_q <= last_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/fpu_sched.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | fpu_sched : shares one iterative FPU between two requesters         |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module fpu_sched
   import fpu_sched_pkg::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT,
   parameter int unsigned TOUT_W  = TOUT_W_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  req_valid_i,
   output logic [1:0]  req_ready_o,
   input  logic [6:0]  req_funct7_0_i,
   input  logic [6:0]  req_funct7_1_i,
   input  logic [31:0] req_a_0_i,
   input  logic [31:0] req_a_1_i,
   input  logic [31:0] req_b_0_i,
   input  logic [31:0] req_b_1_i,
   input  logic [4:0]  req_rd_0_i,
   input  logic [4:0]  req_rd_1_i,
   input  logic        req_ireg_0_i,
   input  logic        req_ireg_1_i,
   output logic        fpu_go_o,
   output logic [6:0]  fpu_funct7_o,
   output logic [31:0] fpu_a_o,
   output logic [31:0] fpu_b_o,
   input  logic        fpu_valid_i,
   input  logic [31:0] fpu_result_i,
   output logic [1:0]  resp_valid_o,
   output logic [31:0] resp_data_o,
   output logic [4:0]  resp_rd_o,
   output logic        resp_ireg_o,
   output logic        resp_err_o,
   output logic        busy_o
);

   localparam logic [TOUT_W-1:0] C_CNT_LAST = TOUT_W'(TIMEOUT - 1);

   schedstate_t       state_q;
   logic [6:0]        funct7_q;
   logic [31:0]       a_q;
   logic [31:0]       b_q;
   logic [4:0]        rd_q;
   logic              ireg_q;
   reqid_t            owner_q;
   logic [TOUT_W-1:0] cnt_q;
   logic              fpu_go_q;
   logic [1:0]        resp_valid_q;
   logic [31:0]       resp_data_q;
   logic [4:0]        resp_rd_q;
   logic              resp_ireg_q;
   logic              resp_err_q;

   logic [1:0]        grant;
   logic              accept;
   reqid_t            win_id;
   logic [6:0]        win_funct7;
   logic [31:0]       win_a;
   logic [31:0]       win_b;
   logic [4:0]        win_rd;
   logic              win_ireg;

   fpu_rr_arb u_arb (
      .clk    (clk),
      .rst    (rst),
      .req    (req_valid_i),
      .accept (accept),
      .grant  (grant)
   );

   // Reset gates ready directly so nothing is offered while rst is high.
   assign req_ready_o = ((state_q == IDLE) && !rst) ? grant : 2'b00;
   assign accept      = |(req_valid_i & req_ready_o);
   assign win_id      = grant[1];

   assign win_funct7 = win_id ? req_funct7_1_i : req_funct7_0_i;
   assign win_a      = win_id ? req_a_1_i      : req_a_0_i;
   assign win_b      = win_id ? req_b_1_i      : req_b_0_i;
   assign win_rd     = win_id ? req_rd_1_i     : req_rd_0_i;
   assign win_ireg   = win_id ? req_ireg_1_i   : req_ireg_0_i;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         funct7_q     <= '0;
         a_q          <= '0;
         b_q          <= '0;
         rd_q         <= '0;
         ireg_q       <= 1'b0;
         owner_q      <= 1'b0;
         cnt_q        <= '0;
         fpu_go_q     <= 1'b0;
         resp_valid_q <= 2'b00;
         resp_data_q  <= '0;
         resp_rd_q    <= '0;
         resp_ireg_q  <= 1'b0;
         resp_err_q   <= 1'b0;
      end else begin
         fpu_go_q     <= 1'b0;
         resp_valid_q <= 2'b00;
         case (state_q)
            IDLE: begin
               if (accept) begin
                  funct7_q <= win_funct7;
                  a_q      <= win_a;
                  b_q      <= win_b;
                  rd_q     <= win_rd;
                  ireg_q   <= win_ireg;
                  owner_q  <= win_id;
                  fpu_go_q <= 1'b1;
                  state_q  <= ISSUE;
               end
            end
            ISSUE: begin
               cnt_q   <= '0;
               state_q <= WAIT;
            end
            WAIT: begin
               // A completion in the watchdog's final cycle still counts as success.
               if (fpu_valid_i) begin
                  resp_data_q  <= fpu_result_i;
                  resp_err_q   <= 1'b0;
                  resp_rd_q    <= rd_q;
                  resp_ireg_q  <= ireg_q;
                  resp_valid_q <= id_onehot(owner_q);
                  state_q      <= RESP;
               end else if (cnt_q == C_CNT_LAST) begin
                  resp_data_q  <= '0;
                  resp_err_q   <= 1'b1;
                  resp_rd_q    <= rd_q;
                  resp_ireg_q  <= ireg_q;
                  resp_valid_q <= id_onehot(owner_q);
                  state_q      <= RESP;
               end else begin
                  cnt_q <= cnt_q + TOUT_W'(1);
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign fpu_go_o     = fpu_go_q;
   assign fpu_funct7_o = funct7_q;
   assign fpu_a_o      = a_q;
   assign fpu_b_o      = b_q;
   assign resp_valid_o = resp_valid_q;
   assign resp_data_o  = resp_data_q;
   assign resp_rd_o    = resp_rd_q;
   assign resp_ireg_o  = resp_ireg_q;
   assign resp_err_o   = resp_err_q;
   assign busy_o       = (state_q != IDLE);

endmodule
`default_nettype wire
